// File: rtl/benes_pkg.sv
// Shared sizing helpers and types for the Benes network configuration path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package benes_pkg;

    localparam int SIZE_DEF      = 8;
    localparam int STAGE_LAT_DEF = 2;

    function automatic int layer_num(input int size);
        return $clog2(size);
    endfunction

    function automatic int stage_num(input int size);
        return 2 * layer_num(size) - 1;
    endfunction

    function automatic int switch_num(input int size);
        return size / 2;
    endfunction

    typedef logic [switch_num(SIZE_DEF)-1:0]        sw_set_t;
    typedef logic [$clog2(stage_num(SIZE_DEF))-1:0] stage_idx_t;

endpackage

// File: rtl/benes_cfg_ctrl_if.sv
// Host-side configuration write bus: one stage write per valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: controller drops cfg_ready while a commit wave is in flight.
interface benes_cfg_ctrl_if #(
    parameter int STAGE_W    = 3,
    parameter int SWITCH_NUM = 4
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [STAGE_W-1:0]    cfg_stage;
    logic [SWITCH_NUM-1:0] cfg_bits;
    logic                  cfg_last;

    modport master (
        output cfg_valid,
        output cfg_stage,
        output cfg_bits,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_stage,
        input  cfg_bits,
        input  cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/benes_vld_pipe.sv
// Resettable 1-bit delay line exposing every tap; taps[i] is din delayed i+1 cycles.
// Latency: DEPTH cycles to the last tap.
// Backpressure: none, shifts every cycle.
module benes_vld_pipe #(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [DEPTH-1:0] taps
);

    logic [DEPTH-1:0] line_d;
    logic [DEPTH-1:0] line_q;

    always_comb begin
        line_d    = line_q << 1;
        line_d[0] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign taps = line_q;

endmodule

// File: rtl/benes_cfg_ctrl.sv
// Shadow/active switch-setting banks for the Benes network; commits ride a wavefront token.
// Latency: stage s goes live 1+s*STAGE_LAT cycles after the committing write; out_valid lags in_valid by PIPE_LAT.
// Backpressure: cfg_ready low for the whole commit wave; the datapath is never stalled.
module benes_cfg_ctrl
    import benes_pkg::*;
#(
    parameter  int SIZE       = SIZE_DEF,
    parameter  int STAGE_LAT  = STAGE_LAT_DEF,
    parameter  int EPOCH_W    = 8,
    localparam int LAYER_NUM  = layer_num(SIZE),
    localparam int STAGE_NUM  = 2 * LAYER_NUM - 1,
    localparam int SWITCH_NUM = switch_num(SIZE),
    localparam int STAGE_W    = $clog2(STAGE_NUM),
    localparam int PIPE_LAT   = STAGE_LAT * STAGE_NUM - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    benes_cfg_ctrl_if.slave       cfg,
    input  logic                  in_valid,
    output logic                  out_valid,
    output logic [SWITCH_NUM-1:0] switch_set [STAGE_NUM],
    output logic                  cfg_busy,
    output logic                  cfg_err,
    output logic [EPOCH_W-1:0]    cfg_epoch
);

    localparam int TOK_DEPTH = (STAGE_NUM - 1) * STAGE_LAT + 1;

    logic [SWITCH_NUM-1:0] shadow_d [STAGE_NUM];
    logic [SWITCH_NUM-1:0] shadow_q [STAGE_NUM];
    logic [SWITCH_NUM-1:0] active_d [STAGE_NUM];
    logic [SWITCH_NUM-1:0] active_q [STAGE_NUM];
    logic                  busy_d, busy_q;
    logic                  err_d, err_q;
    logic [EPOCH_W-1:0]    epoch_d, epoch_q;

    logic                  wr_fire;
    logic                  commit_fire;
    logic                  stage_ok;
    logic [TOK_DEPTH-1:0]  tok;
    logic [PIPE_LAT-1:0]   vld_taps;

    assign wr_fire     = cfg.cfg_valid && cfg.cfg_ready;
    assign commit_fire = wr_fire && cfg.cfg_last;
    assign stage_ok    = int'(cfg.cfg_stage) < STAGE_NUM;

    // Token enters the line at the committing edge; tap s*STAGE_LAT then
    // lines up with the datapath wavefront reaching stage s.
    benes_vld_pipe #(.DEPTH(TOK_DEPTH)) u_tok_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (commit_fire),
        .taps  (tok)
    );

    benes_vld_pipe #(.DEPTH(PIPE_LAT)) u_vld_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in_valid),
        .taps  (vld_taps)
    );

    always_comb begin
        shadow_d = shadow_q;
        if (wr_fire && stage_ok) begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (int'(cfg.cfg_stage) == s) begin
                    shadow_d[s] = cfg.cfg_bits;
                end
            end
        end
    end

    always_comb begin
        active_d = active_q;
        for (int s = 0; s < STAGE_NUM; s++) begin
            if (tok[s*STAGE_LAT]) begin
                active_d[s] = shadow_q[s];
            end
        end
    end

    always_comb begin
        busy_d  = busy_q;
        epoch_d = epoch_q;
        err_d   = err_q | (wr_fire && !stage_ok);
        if (commit_fire) begin
            busy_d = 1'b1;
        end else if (tok[TOK_DEPTH-1]) begin
            busy_d = 1'b0;
        end
        if (tok[TOK_DEPTH-1]) begin
            epoch_d = epoch_q + EPOCH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                shadow_q[s] <= '0;
                active_q[s] <= '0;
            end
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            epoch_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            epoch_q  <= epoch_d;
        end
    end

    assign cfg.cfg_ready = ~busy_q;
    assign cfg_busy      = busy_q;
    assign cfg_err       = err_q;
    assign cfg_epoch     = epoch_q;
    assign switch_set    = active_q;
    assign out_valid     = vld_taps[PIPE_LAT-1];

endmodule

// File: tb/tb_benes_cfg_ctrl.sv
// Self-checking bench for benes_cfg_ctrl (SIZE=8): directed commit scenarios plus random traffic
// against an edge-counting reference model of the commit wave and valid delay.
module tb_benes_cfg_ctrl;
    import benes_pkg::*;

    localparam int ST   = 5;
    localparam int SW   = 4;
    localparam int LAT  = 2;
    localparam int PLAT = LAT * ST - 1;
    localparam int WAVE = 1 + (ST - 1) * LAT;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_valid;
    logic [SW-1:0] sw [ST];
    logic cfg_busy, cfg_err;
    logic [7:0] cfg_epoch;

    benes_cfg_ctrl_if #(.STAGE_W(3), .SWITCH_NUM(SW)) cif ();

    benes_cfg_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cif.slave),
        .in_valid   (in_valid),
        .out_valid  (out_valid),
        .switch_set (sw),
        .cfg_busy   (cfg_busy),
        .cfg_err    (cfg_err),
        .cfg_epoch  (cfg_epoch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int      cyc = 0;
    int      commit_k = -1;
    sw_set_t shadow_m [ST];
    sw_set_t active_m [ST];
    sw_set_t snap_m   [ST];
    bit      err_m = 1'b0;
    int      epoch_m = 0;
    bit      hist [HMAX];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit busy_m();
        return commit_k >= 0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < ST; s++) begin
            shadow_m[s] = '0;
            active_m[s] = '0;
            snap_m[s]   = '0;
        end
        commit_k = -1;
        err_m    = 1'b0;
        epoch_m  = 0;
        for (int i = 0; i < HMAX; i++) hist[i] = 1'b0;
    endtask

    task automatic check_all();
        for (int s = 0; s < ST; s++) chk($sformatf("switch_set[%0d]", s), 32'(sw[s]), 32'(active_m[s]));
        chk("cfg_ready", 32'(cif.cfg_ready), 32'(!busy_m()));
        chk("cfg_busy", 32'(cfg_busy), 32'(busy_m()));
        chk("cfg_err", 32'(cfg_err), 32'(err_m));
        chk("cfg_epoch", 32'(cfg_epoch), 32'(epoch_m % 256));
        chk("out_valid", 32'(out_valid), 32'((cyc >= PLAT - 1) ? hist[cyc - (PLAT - 1)] : 1'b0));
    endtask

    // One clock edge: model what the edge does, then compare just after it.
    task automatic step();
        if (cif.cfg_valid && !busy_m()) begin
            if (int'(cif.cfg_stage) < ST) shadow_m[int'(cif.cfg_stage)] = cif.cfg_bits;
            else err_m = 1'b1;
            if (cif.cfg_last) begin
                commit_k = cyc + 1;
                for (int s = 0; s < ST; s++) snap_m[s] = shadow_m[s];
            end
        end
        @(posedge clk);
        cyc++;
        hist[cyc] = in_valid;
        #1;
        if (commit_k >= 0) begin
            for (int s = 0; s < ST; s++)
                if (cyc == commit_k + 1 + s * LAT) active_m[s] = snap_m[s];
            if (cyc == commit_k + WAVE) begin
                epoch_m++;
                commit_k = -1;
            end
        end
        check_all();
    endtask

    task automatic wr(input int stage, input logic [SW-1:0] bits, input bit last);
        int n = 0;
        while (busy_m() && n < 20) begin
            step();
            n++;
        end
        if (busy_m()) chk("wr_wait_timeout", 32'(1), 32'(0));
        cif.cfg_valid = 1'b1;
        cif.cfg_stage = 3'(stage);
        cif.cfg_bits  = bits;
        cif.cfg_last  = last;
        step();
        cif.cfg_valid = 1'b0;
        cif.cfg_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        cif.cfg_valid = 1'b0;
        cif.cfg_stage = '0;
        cif.cfg_bits  = '0;
        cif.cfg_last  = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        check_all();
        idle(20);

        // full commit of all stages
        for (int s = 0; s < ST; s++) wr(s, 4'hF, s == ST - 1);
        idle(12);

        // valid pattern through the delay line
        begin
            bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 4; i++) begin
                in_valid = pat[i];
                step();
            end
            in_valid = 1'b0;
            idle(12);
        end

        // partial update of a single stage
        wr(2, 4'h5, 1'b1);
        idle(12);

        // out-of-range stage still commits
        wr(7, 4'hA, 1'b1);
        idle(12);

        // reset in the middle of a wave
        wr(0, 4'h3, 1'b0);
        wr(4, 4'h6, 1'b1);
        idle(3);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
        idle(15);

        // random traffic, including writes attempted while busy
        for (int i = 0; i < 1500; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                cif.cfg_valid = 1'b1;
                cif.cfg_stage = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                cif.cfg_bits  = 4'($urandom);
                cif.cfg_last  = ($urandom_range(0, 3) == 0);
            end else begin
                cif.cfg_valid = 1'b0;
                cif.cfg_last  = 1'b0;
            end
            step();
        end
        cif.cfg_valid = 1'b0;
        in_valid = 1'b0;
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
